// File: rtl/spi_frame_ctrl_pkg.sv
// spi_frame_ctrl_pkg: shared state encoding and constants for the SPI frame sequencer.
package spi_frame_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, CMD, WR, RD_FETCH, RD_WAIT, RD_DATA} state_e;
    localparam int CMD_RW_BIT = 7;
    localparam logic [7:0] STATUS_DEFAULT = 8'hA5;
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/spi_frame_ctrl_addr_gen.sv
// spi_frame_ctrl_addr_gen: loadable AW-bit register address counter with wrapping increment.
module spi_frame_ctrl_addr_gen #(
    parameter int AW       = 7,
    parameter bit AUTO_INC = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          ena_i,
    input  logic          load_i,
    input  logic [AW-1:0] load_val_i,
    input  logic          inc_i,
    output logic [AW-1:0] addr_o
);
    logic [AW-1:0] addr_q, addr_d;
    assign addr_d = load_i ? load_val_i : (inc_i && AUTO_INC) ? addr_q + AW'(1) : addr_q;
    assign addr_o = addr_q;
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) addr_q <= '0;
        else if (ena_i) addr_q <= addr_d;
endmodule

// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: decodes a {rw,addr} command byte and streams data bytes to/from a register bus.
module spi_frame_ctrl import spi_frame_ctrl_pkg::*; #(
    parameter int         AW       = 7,
    parameter bit         AUTO_INC = 1'b1,
    parameter logic [7:0] STATUS   = STATUS_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          ena_i,
    input  logic          spi_ss_i,
    input  logic          rx_req_i,
    input  logic [7:0]    rx_byte_i,
    input  logic          tx_req_i,
    output logic [7:0]    tx_byte_o,
    output logic [AW-1:0] reg_addr_o,
    output logic [7:0]    reg_wdata_o,
    output logic          reg_we_o,
    output logic          reg_re_o,
    input  logic [7:0]    reg_rdata_i,
    output logic          busy_o,
    output logic          err_ovr_o,
    output logic [7:0]    byte_cnt_o
);
    state_e     state_q;
    logic [7:0] tx_byte_q, wdata_q, cnt_q;
    logic       we_q, re_q, err_q;
    logic       addr_load, addr_inc;

    // The address moves once the write strobe has gone out, or when a read byte is consumed.
    assign addr_load = !spi_ss_i && state_q == CMD && rx_req_i;
    assign addr_inc  = !spi_ss_i && ((state_q == WR && we_q) || (state_q == RD_DATA && tx_req_i));

    spi_frame_ctrl_addr_gen #(.AW(AW), .AUTO_INC(AUTO_INC)) u_addr (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .ena_i      (ena_i),
        .load_i     (addr_load),
        .load_val_i (rx_byte_i[AW-1:0]),
        .inc_i      (addr_inc),
        .addr_o     (reg_addr_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            tx_byte_q <= STATUS;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else if (ena_i) begin
            we_q <= 1'b0;
            re_q <= 1'b0;
            if (spi_ss_i) state_q <= IDLE;
            else case (state_q)
                IDLE: begin
                    state_q   <= CMD;
                    err_q     <= 1'b0;
                    cnt_q     <= '0;
                    tx_byte_q <= STATUS;
                end
                CMD: if (rx_req_i) begin
                    state_q <= rx_byte_i[CMD_RW_BIT] ? RD_FETCH : WR;
                    re_q    <= rx_byte_i[CMD_RW_BIT];
                end
                WR: begin
                    if (rx_req_i) begin
                        we_q    <= 1'b1;
                        wdata_q <= rx_byte_i;
                    end
                    if (we_q) cnt_q <= sat_inc(cnt_q);
                end
                RD_FETCH: begin
                    state_q <= RD_WAIT;
                    if (tx_req_i) err_q <= 1'b1;
                end
                RD_WAIT: begin
                    state_q   <= RD_DATA;
                    tx_byte_q <= reg_rdata_i;
                    if (tx_req_i) err_q <= 1'b1;
                end
                RD_DATA: if (tx_req_i) begin
                    state_q <= RD_FETCH;
                    re_q    <= 1'b1;
                    cnt_q   <= sat_inc(cnt_q);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_byte_o   = tx_byte_q;
    assign reg_wdata_o = wdata_q;
    assign reg_we_o    = we_q;
    assign reg_re_o    = re_q;
    assign busy_o      = state_q != IDLE;
    assign err_ovr_o   = err_q;
    assign byte_cnt_o  = cnt_q;
endmodule

// File: tb/tb_spi_frame_ctrl.sv
// tb_spi_frame_ctrl: byte-level frame stimulus with write/read scoreboards and a register memory model.
module tb_spi_frame_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b1, spi_ss = 1'b1, rx_req = 1'b0, tx_req = 1'b0;
    logic [7:0] rx_byte = 8'h00, reg_rdata, tx_byte, reg_wdata, byte_cnt;
    logic [6:0] reg_addr;
    logic       reg_we, reg_re, busy, err_ovr;

    spi_frame_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .ena_i(ena), .spi_ss_i(spi_ss),
        .rx_req_i(rx_req), .rx_byte_i(rx_byte), .tx_req_i(tx_req), .tx_byte_o(tx_byte),
        .reg_addr_o(reg_addr), .reg_wdata_o(reg_wdata), .reg_we_o(reg_we), .reg_re_o(reg_re),
        .reg_rdata_i(reg_rdata), .busy_o(busy), .err_ovr_o(err_ovr), .byte_cnt_o(byte_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [6:0] addr; logic [7:0] data; } wr_t;
    typedef struct { logic [7:0] cmd, d0, d1, cnt; logic [6:0] a0, a1, end_a; } wvec_t;
    typedef struct { logic [7:0] cmd, r0, r1, cnt; logic [6:0] end_a; } rvec_t;

    int         n_tests = 0, n_fail = 0;
    wr_t        wr_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] mem [128];
    wr_t        mon_e;
    wvec_t      wtab [3];
    rvec_t      rtab [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Register bus model: read data is valid exactly one clock after reg_re.
    always @(posedge clk) reg_rdata <= reg_re ? mem[reg_addr] : 8'hEE;

    always @(negedge clk) if (reg_we) begin
        if (wr_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", reg_addr, reg_wdata);
        end else begin
            mon_e = wr_q.pop_front();
            check("wr_addr", 32'(reg_addr), 32'(mon_e.addr));
            check("wr_data", 32'(reg_wdata), 32'(mon_e.data));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b, input int gap = 6);
        tick(gap);
        rx_byte = b;
        rx_req = 1'b1;
        tick();
        rx_req = 1'b0;
    endtask

    task automatic do_tx(input string name);
        tick(4);
        tx_req = 1'b1;
        if (rd_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got tx %0h, expected no tx request", name, tx_byte);
        end else check(name, 32'(tx_byte), 32'(rd_q.pop_front()));
        tick();
        tx_req = 1'b0;
    endtask

    task automatic start_frame();
        spi_ss = 1'b0;
        tick();
        check("start_busy", 32'(busy), 1);
        check("start_status", 32'(tx_byte), 32'h A5);
        check("start_cnt", 32'(byte_cnt), 0);
    endtask

    task automatic end_frame();
        spi_ss = 1'b1;
        tick();
        check("end_busy", 32'(busy), 0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'(i * 3) ^ 8'h5A;
        mem[3] = 8'h3C; mem[4] = 8'h4D; mem[127] = 8'h77; mem[0] = 8'h99;
        wtab[0] = '{cmd: 8'h05, d0: 8'h11, d1: 8'h22, cnt: 8'd2, a0: 7'h05, a1: 7'h06, end_a: 7'h07};
        wtab[1] = '{cmd: 8'h7F, d0: 8'hAA, d1: 8'hBB, cnt: 8'd2, a0: 7'h7F, a1: 7'h00, end_a: 7'h01};
        wtab[2] = '{cmd: 8'h10, d0: 8'h01, d1: 8'hFE, cnt: 8'd2, a0: 7'h10, a1: 7'h11, end_a: 7'h12};
        rtab[0] = '{cmd: 8'h83, r0: 8'h3C, r1: 8'h4D, cnt: 8'd2, end_a: 7'h05};
        rtab[1] = '{cmd: 8'hFF, r0: 8'h77, r1: 8'h99, cnt: 8'd2, end_a: 7'h01};

        tick(2);
        check("rst_status", 32'(tx_byte), 32'hA5);
        check("rst_busy", 32'(busy), 0);
        check("rst_we_re", {reg_we, reg_re, err_ovr}, 0);
        check("rst_addr_wdata_cnt", {reg_addr, reg_wdata, byte_cnt}, 0);
        rst_n = 1'b1;
        tick(2);
        check("idle_hold_busy", 32'(busy), 0);

        foreach (wtab[k]) begin
            start_frame();
            send_rx(wtab[k].cmd);
            wr_q.push_back('{wtab[k].a0, wtab[k].d0});
            wr_q.push_back('{wtab[k].a1, wtab[k].d1});
            send_rx(wtab[k].d0);
            send_rx(wtab[k].d1);
            tick(3);
            check("wr_cnt", 32'(byte_cnt), 32'(wtab[k].cnt));
            check("wr_end_addr", 32'(reg_addr), 32'(wtab[k].end_a));
            check("wr_queue_drained", wr_q.size(), 0);
            end_frame();
        end

        foreach (rtab[k]) begin
            start_frame();
            rd_q.push_back(8'hA5);
            do_tx("rd_status_during_cmd");
            send_rx(rtab[k].cmd);
            rd_q.push_back(rtab[k].r0);
            rd_q.push_back(rtab[k].r1);
            do_tx("rd_byte0");
            send_rx(8'h5C);
            do_tx("rd_byte1");
            tick(3);
            check("rd_cnt", 32'(byte_cnt), 32'(rtab[k].cnt));
            check("rd_end_addr", 32'(reg_addr), 32'(rtab[k].end_a));
            check("rd_no_ovr", 32'(err_ovr), 0);
            end_frame();
        end

        // Abort mid data byte with a coincident rx strobe: spi_ss wins, no write.
        start_frame();
        send_rx(8'h20);
        wr_q.push_back('{7'h20, 8'h5A});
        send_rx(8'h5A);
        tick(3);
        check("abort_cnt_before", 32'(byte_cnt), 1);
        spi_ss = 1'b1;
        rx_byte = 8'hFF;
        rx_req = 1'b1;
        tick();
        rx_req = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_no_we", 32'(reg_we), 0);
        tick(3);
        start_frame();
        end_frame();

        // Clock enable low freezes state and drops strobes.
        start_frame();
        send_rx(8'h30);
        ena = 1'b0;
        rx_byte = 8'h99;
        rx_req = 1'b1;
        tick();
        rx_req = 1'b0;
        tick(2);
        check("ena_cnt_frozen", 32'(byte_cnt), 0);
        spi_ss = 1'b1;
        tick();
        check("ena_busy_frozen", 32'(busy), 1);
        spi_ss = 1'b0;
        ena = 1'b1;
        tick(2);
        wr_q.push_back('{7'h30, 8'h66});
        send_rx(8'h66);
        tick(3);
        check("ena_cnt_after", 32'(byte_cnt), 1);
        check("ena_addr_after", 32'(reg_addr), 32'h31);
        end_frame();

        // Overrun: tx_req one clock after the read command.
        start_frame();
        send_rx(8'h83);
        check("rd_re_latency", 32'(reg_re), 1);
        check("rd_re_addr", 32'(reg_addr), 3);
        tx_req = 1'b1;
        tick();
        tx_req = 1'b0;
        check("ovr_set", 32'(err_ovr), 1);
        check("ovr_re_one_clk", 32'(reg_re), 0);
        check("ovr_stale_tx", 32'(tx_byte), 32'hA5);
        tick();
        check("rd_tx_valid_3clk", 32'(tx_byte), 32'h3C);
        rd_q.push_back(8'h3C);
        do_tx("ovr_fetched_byte");
        check("ovr_sticky_frame", 32'(err_ovr), 1);
        end_frame();
        check("ovr_sticky_idle", 32'(err_ovr), 1);
        start_frame();
        check("ovr_cleared", 32'(err_ovr), 0);
        end_frame();

        // Saturating byte count across 257 writes with address wrap.
        start_frame();
        send_rx(8'h40);
        for (int i = 0; i < 257; i++) begin
            wr_q.push_back('{7'(8'h40 + i), 8'(i)});
            send_rx(8'(i), 1);
        end
        tick(3);
        check("sat_cnt", 32'(byte_cnt), 32'hFF);
        check("sat_end_addr", 32'(reg_addr), 32'h41);
        end_frame();

        // Asynchronous reset in the middle of a read.
        start_frame();
        send_rx(8'h83);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_re", 32'(reg_re), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_status", 32'(tx_byte), 32'hA5);
        check("arst_addr_wdata_cnt", {reg_addr, reg_wdata, byte_cnt, 7'd0, err_ovr}, 0);
        spi_ss = 1'b1;
        tick(2);
        check("arst_no_re", 32'(reg_re), 0);
        rst_n = 1'b1;
        tick(2);
        check("arst_idle", 32'(busy), 0);

        check("final_wr_queue", wr_q.size(), 0);
        check("final_rd_queue", rd_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
